// File: rtl/ck_div_src.sv
// ck_div_src: programmable glitch-free clock divider.
//
// Divides CK by a runtime-selectable ratio N >= 2 and produces the registered
// single-phase clock CK_OUT for the downstream two-phase generator. Each period
// is H = floor(N/2) cycles high followed by L = N - H cycles low, so odd ratios
// put the extra cycle in the low phase. Starting and stopping happen only at
// period boundaries, so CK_OUT never carries a runt pulse.
//
// Ports:
//   CK          system clock, all state moves on the rising edge
//   RST         asynchronous active-high reset
//   RUN         1 = generate clock, 0 = finish the current period then park low
//   DIV_IN      requested divide ratio (values below 2 are treated as 2)
//   DIV_REQ     request to capture DIV_IN into the shadow divisor
//   DIV_ACK     one-cycle pulse confirming a shadow capture
//   DIV_ACT     divisor governing the period in progress
//   CK_OUT      divided clock, registered
//   BUSY        high whenever the divider is not idle
//   PERIOD_CNT  count of completed periods, wraps modulo 2^WIDTH

module ck_div_src #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             RUN,
    input  logic [WIDTH-1:0] DIV_IN,
    input  logic             DIV_REQ,
    output logic             DIV_ACK,
    output logic [WIDTH-1:0] DIV_ACT,
    output logic             CK_OUT,
    output logic             BUSY,
    output logic [WIDTH-1:0] PERIOD_CNT
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] ph_cnt;

    logic [WIDTH-1:0] div_clean;   // DIV_IN clamped to a legal ratio
    logic [WIDTH-1:0] shadow_hm1;  // high-phase reload for a period started from shadow
    logic [WIDTH-1:0] act_lm1;     // low-phase reload for the period in progress

    always_comb begin
        div_clean  = (DIV_IN < TWO) ? TWO : DIV_IN;
        shadow_hm1 = (shadow >> 1) - ONE;
        act_lm1    = DIV_ACT - (DIV_ACT >> 1) - ONE;
    end

    // Divisor handshake. A capture is only allowed while DIV_ACK is low, so a
    // held request re-captures every second cycle. The FSM below reads the
    // registered shadow, so a capture on a boundary edge only affects the
    // period after next.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            shadow  <= TWO;
            DIV_ACK <= 1'b0;
        end else if (DIV_REQ && !DIV_ACK) begin
            shadow  <= div_clean;
            DIV_ACK <= 1'b1;
        end else begin
            DIV_ACK <= 1'b0;
        end
    end

    // Period FSM with registered outputs. RUN is looked at only in idle and in
    // the last low cycle, so dropping it mid-period never shortens a phase.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state      <= StIdle;
            ph_cnt     <= '0;
            DIV_ACT    <= TWO;
            CK_OUT     <= 1'b0;
            BUSY       <= 1'b0;
            PERIOD_CNT <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (RUN) begin
                        state   <= StHigh;
                        DIV_ACT <= shadow;
                        ph_cnt  <= shadow_hm1;
                        CK_OUT  <= 1'b1;
                        BUSY    <= 1'b1;
                    end
                end

                StHigh: begin
                    if (ph_cnt == '0) begin
                        state  <= StLow;
                        ph_cnt <= act_lm1;
                        CK_OUT <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt - ONE;
                    end
                end

                StLow: begin
                    if (ph_cnt == '0) begin
                        PERIOD_CNT <= PERIOD_CNT + ONE;
                        if (RUN) begin
                            // Back-to-back period: no gap cycle.
                            state   <= StHigh;
                            DIV_ACT <= shadow;
                            ph_cnt  <= shadow_hm1;
                            CK_OUT  <= 1'b1;
                        end else begin
                            state <= StIdle;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        ph_cnt <= ph_cnt - ONE;
                    end
                end

                default: begin
                    state  <= StIdle;
                    ph_cnt <= '0;
                    CK_OUT <= 1'b0;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ck_div_src.sv
// Directed testbench for ck_div_src. A WIDTH=8 instance covers the main
// function; a WIDTH=4 instance covers counter wrap and the held-request case.

module tb_ck_div_src;

    logic       CK;
    logic       RST;
    logic       RUN;
    logic [7:0] DIV_IN;
    logic       DIV_REQ;
    logic       DIV_ACK;
    logic [7:0] DIV_ACT;
    logic       CK_OUT;
    logic       BUSY;
    logic [7:0] PERIOD_CNT;

    logic       rst4;
    logic       run4;
    logic [3:0] div_in4;
    logic       div_req4;
    logic       div_ack4;
    logic [3:0] div_act4;
    logic       ck_out4;
    logic       busy4;
    logic [3:0] period_cnt4;

    int vectors;
    int miscompares;

    ck_div_src #(.WIDTH(8)) u_dut (
        .CK         (CK),
        .RST        (RST),
        .RUN        (RUN),
        .DIV_IN     (DIV_IN),
        .DIV_REQ    (DIV_REQ),
        .DIV_ACK    (DIV_ACK),
        .DIV_ACT    (DIV_ACT),
        .CK_OUT     (CK_OUT),
        .BUSY       (BUSY),
        .PERIOD_CNT (PERIOD_CNT)
    );

    ck_div_src #(.WIDTH(4)) u_dut4 (
        .CK         (CK),
        .RST        (rst4),
        .RUN        (run4),
        .DIV_IN     (div_in4),
        .DIV_REQ    (div_req4),
        .DIV_ACK    (div_ack4),
        .DIV_ACT    (div_act4),
        .CK_OUT     (ck_out4),
        .BUSY       (busy4),
        .PERIOD_CNT (period_cnt4)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        RST     = 1'b1;
        RUN     = 1'b0;
        DIV_REQ = 1'b0;
        DIV_IN  = 8'd0;
        step();
        RST = 1'b0;
    endtask

    // Load the shadow divisor through one handshake, leaves DIV_REQ low.
    task automatic load_div(input logic [7:0] n);
        DIV_IN  = n;
        DIV_REQ = 1'b1;
        step();
        DIV_REQ = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (BUSY === 1'b1 && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_idle: BUSY=%b after %0d cycles, want 0", BUSY, n);
        end
    endtask

    task automatic test_reset();
        vectors += 5;
        if (CK_OUT !== 1'b0) begin
            miscompares++; $display("FAIL reset_ck_out: got %b want 0", CK_OUT);
        end
        if (BUSY !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b want 0", BUSY);
        end
        if (DIV_ACK !== 1'b0) begin
            miscompares++; $display("FAIL reset_ack: got %b want 0", DIV_ACK);
        end
        if (DIV_ACT !== 8'd2) begin
            miscompares++; $display("FAIL reset_div_act: got %0d want 2", DIV_ACT);
        end
        if (PERIOD_CNT !== 8'd0) begin
            miscompares++; $display("FAIL reset_period_cnt: got %0d want 0", PERIOD_CNT);
        end
    endtask

    task automatic test_default_run();
        logic [7:0] exp_pc;
        do_reset();
        RUN = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp_pc = 8'((e - 1) / 2);
            vectors += 4;
            if (CK_OUT !== ((e % 2) == 1)) begin
                miscompares++;
                $display("FAIL default_ck_out[%0d]: got %b want %b", e, CK_OUT, (e % 2) == 1);
            end
            if (PERIOD_CNT !== exp_pc) begin
                miscompares++;
                $display("FAIL default_pc[%0d]: got %0d want %0d", e, PERIOD_CNT, exp_pc);
            end
            if (DIV_ACT !== 8'd2) begin
                miscompares++; $display("FAIL default_div_act[%0d]: got %0d want 2", e, DIV_ACT);
            end
            if (BUSY !== 1'b1) begin
                miscompares++; $display("FAIL default_busy[%0d]: got %b want 1", e, BUSY);
            end
        end
        // Edge 8 left us in the last low cycle; stopping now ends cleanly.
        RUN = 1'b0;
        step();
        vectors += 3;
        if (BUSY !== 1'b0) begin
            miscompares++; $display("FAIL default_stop_busy: got %b want 0", BUSY);
        end
        if (CK_OUT !== 1'b0) begin
            miscompares++; $display("FAIL default_stop_ck: got %b want 0", CK_OUT);
        end
        if (PERIOD_CNT !== 8'd4) begin
            miscompares++; $display("FAIL default_stop_pc: got %0d want 4", PERIOD_CNT);
        end
    endtask

    task automatic test_div_load();
        logic [7:0]  pat4;
        logic [9:0]  pat5;
        pat4 = 8'b1100_1100;
        pat5 = 10'b11000_11000;
        do_reset();

        DIV_IN  = 8'd4;
        DIV_REQ = 1'b1;
        step();
        vectors += 2;
        if (DIV_ACK !== 1'b1) begin
            miscompares++; $display("FAIL load4_ack: got %b want 1", DIV_ACK);
        end
        if (DIV_ACT !== 8'd2) begin
            miscompares++; $display("FAIL load4_act_idle: got %0d want 2", DIV_ACT);
        end
        DIV_REQ = 1'b0;
        step();
        vectors++;
        if (DIV_ACK !== 1'b0) begin
            miscompares++; $display("FAIL load4_ack_drop: got %b want 0", DIV_ACK);
        end

        RUN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors += 2;
            if (CK_OUT !== pat4[7-i]) begin
                miscompares++;
                $display("FAIL n4_ck_out[%0d]: got %b want %b", i, CK_OUT, pat4[7-i]);
            end
            if (DIV_ACT !== 8'd4) begin
                miscompares++; $display("FAIL n4_div_act[%0d]: got %0d want 4", i, DIV_ACT);
            end
        end
        RUN = 1'b0;
        wait_idle(20);

        load_div(8'd5);
        RUN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors += 2;
            if (CK_OUT !== pat5[9-i]) begin
                miscompares++;
                $display("FAIL n5_ck_out[%0d]: got %b want %b", i, CK_OUT, pat5[9-i]);
            end
            if (DIV_ACT !== 8'd5) begin
                miscompares++; $display("FAIL n5_div_act[%0d]: got %0d want 5", i, DIV_ACT);
            end
        end
        RUN = 1'b0;
        wait_idle(20);

        load_div(8'd0);
        RUN = 1'b1;
        step();
        vectors += 2;
        if (DIV_ACT !== 8'd2) begin
            miscompares++; $display("FAIL n0_div_act: got %0d want 2", DIV_ACT);
        end
        if (CK_OUT !== 1'b1) begin
            miscompares++; $display("FAIL n0_ck_out: got %b want 1", CK_OUT);
        end
        RUN = 1'b0;
        wait_idle(20);
    endtask

    task automatic test_mid_period_change();
        logic [9:0] pat;
        logic [7:0] exp_act;
        pat = 10'b111000_100_1;
        do_reset();
        load_div(8'd6);
        RUN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_act = (i < 6) ? 8'd6 : 8'd3;
            vectors += 2;
            if (CK_OUT !== pat[9-i]) begin
                miscompares++;
                $display("FAIL change_ck_out[%0d]: got %b want %b", i, CK_OUT, pat[9-i]);
            end
            if (DIV_ACT !== exp_act) begin
                miscompares++;
                $display("FAIL change_div_act[%0d]: got %0d want %0d", i, DIV_ACT, exp_act);
            end
            if (i == 0) begin
                DIV_IN  = 8'd3;
                DIV_REQ = 1'b1;
            end
            if (i == 1) begin
                vectors++;
                if (DIV_ACK !== 1'b1) begin
                    miscompares++; $display("FAIL change_ack: got %b want 1", DIV_ACK);
                end
                DIV_REQ = 1'b0;
            end
        end
        RUN = 1'b0;
        wait_idle(20);
    endtask

    task automatic test_stop_mid_high();
        logic [10:0] pat;
        logic [7:0]  exp_pc;
        pat = 11'b1111_0000_000;
        do_reset();
        load_div(8'd8);
        RUN = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            exp_pc = (i < 8) ? 8'd0 : 8'd1;
            vectors += 3;
            if (CK_OUT !== pat[10-i]) begin
                miscompares++;
                $display("FAIL stop_ck_out[%0d]: got %b want %b", i, CK_OUT, pat[10-i]);
            end
            if (BUSY !== (i < 8)) begin
                miscompares++;
                $display("FAIL stop_busy[%0d]: got %b want %b", i, BUSY, i < 8);
            end
            if (PERIOD_CNT !== exp_pc) begin
                miscompares++;
                $display("FAIL stop_pc[%0d]: got %0d want %0d", i, PERIOD_CNT, exp_pc);
            end
            if (i == 1) RUN = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_div(8'd10);
        RUN = 1'b1;
        step();
        step();
        vectors++;
        if (CK_OUT !== 1'b1) begin
            miscompares++; $display("FAIL arst_pre_ck: got %b want 1", CK_OUT);
        end
        #2;
        RST = 1'b1;
        #1;
        vectors += 5;
        if (CK_OUT !== 1'b0) begin
            miscompares++; $display("FAIL arst_ck_out: got %b want 0", CK_OUT);
        end
        if (BUSY !== 1'b0) begin
            miscompares++; $display("FAIL arst_busy: got %b want 0", BUSY);
        end
        if (DIV_ACT !== 8'd2) begin
            miscompares++; $display("FAIL arst_div_act: got %0d want 2", DIV_ACT);
        end
        if (PERIOD_CNT !== 8'd0) begin
            miscompares++; $display("FAIL arst_pc: got %0d want 0", PERIOD_CNT);
        end
        if (DIV_ACK !== 1'b0) begin
            miscompares++; $display("FAIL arst_ack: got %b want 0", DIV_ACK);
        end
        #1;
        RST = 1'b0;
        step();
        vectors += 2;
        if (CK_OUT !== 1'b1 || DIV_ACT !== 8'd2) begin
            miscompares++;
            $display("FAIL arst_restart: ck=%b act=%0d want ck=1 act=2", CK_OUT, DIV_ACT);
        end
        step();
        if (CK_OUT !== 1'b0) begin
            miscompares++; $display("FAIL arst_restart_low: got %b want 0", CK_OUT);
        end
        step();
        vectors++;
        if (CK_OUT !== 1'b1 || PERIOD_CNT !== 8'd1) begin
            miscompares++;
            $display("FAIL arst_restart_p2: ck=%b pc=%0d want ck=1 pc=1", CK_OUT, PERIOD_CNT);
        end
        RUN = 1'b0;
        wait_idle(20);
    endtask

    task automatic test_wrap_and_held_req();
        int acks;
        run4 = 1'b1;
        rst4 = 1'b0;
        for (int e = 1; e <= 33; e++) begin
            step();
            if (e == 31 || e == 32) begin
                vectors++;
                if (period_cnt4 !== 4'd15) begin
                    miscompares++;
                    $display("FAIL wrap_pc15[%0d]: got %0d want 15", e, period_cnt4);
                end
            end
            if (e == 33) begin
                vectors++;
                if (period_cnt4 !== 4'd0) begin
                    miscompares++; $display("FAIL wrap_pc0: got %0d want 0", period_cnt4);
                end
            end
        end

        acks     = 0;
        div_in4  = 4'd2;
        div_req4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (div_ack4 === 1'b1) acks++;
        end
        div_req4 = 1'b0;
        vectors++;
        if (acks != 3) begin
            miscompares++; $display("FAIL held_req_acks: got %0d want 3", acks);
        end
        step();
        vectors++;
        if (div_ack4 !== 1'b0) begin
            miscompares++; $display("FAIL held_req_ack_idle: got %b want 0", div_ack4);
        end
        run4 = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST      = 1'b1;
        RUN      = 1'b0;
        DIV_IN   = 8'd0;
        DIV_REQ  = 1'b0;
        rst4     = 1'b1;
        run4     = 1'b0;
        div_in4  = 4'd0;
        div_req4 = 1'b0;
        #1;

        test_reset();
        test_default_run();
        test_div_load();
        test_mid_period_change();
        test_stop_mid_high();
        test_async_reset();
        test_wrap_and_held_req();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
